// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter: collects results from the ALU, forwarder, jump and branch
// units into per-source FIFOs and drains them round-robin into one registered
// result slot that feeds the ROB write/broadcast port.
module wb_result_arbiter #(
  parameter int N_SRC      = 4,
  parameter int TAG_W      = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  input  logic [N_SRC*TAG_W-1:0]     src_tag,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  output logic                       cdb_valid,
  input  logic                       cdb_ready,
  output logic [$clog2(N_SRC)-1:0]   cdb_src,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       busy
);

  localparam int SW = $clog2(N_SRC);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [TAG_W-1:0]  mem_tag  [N_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [N_SRC][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr   [N_SRC];
  logic [PW-1:0]     rd_ptr   [N_SRC];
  logic [CW-1:0]     count    [N_SRC];

  logic [N_SRC-1:0]  nonempty;
  logic [N_SRC-1:0]  push;
  logic [N_SRC-1:0]  pop;
  logic [SW-1:0]     rr_ptr;
  logic [SW-1:0]     grant;
  logic              grant_vld;
  logic              slot_free;
  logic              load;
  int                scan_idx;

  // Per-source occupancy, acceptance and push qualification (registered count only).
  always_comb begin
    nonempty  = '0;
    src_ready = '0;
    push      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      nonempty[i]  = (count[i] != '0);
      src_ready[i] = !rst && !flush && (count[i] < CW'(FIFO_DEPTH));
      push[i]      = src_valid[i] && src_ready[i];
    end
  end

  // Round-robin scan starting at rr_ptr; scanning backwards lets the
  // earliest source in rotation order overwrite later candidates.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= N_SRC) scan_idx = scan_idx - N_SRC;
      if (nonempty[scan_idx]) begin
        grant     = SW'(scan_idx);
        grant_vld = 1'b1;
      end
    end
  end

  // Slot accepts a new result when empty or being handed to the ROB this cycle.
  always_comb begin
    slot_free = !cdb_valid || cdb_ready;
    load      = slot_free && grant_vld;
    pop       = '0;
    if (load) pop[grant] = 1'b1;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) begin
        mem_tag[i][wr_ptr[i]]  <= src_tag[i*TAG_W +: TAG_W];
        mem_data[i][wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers and counts; flush empties every queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Result slot and rotation pointer; flush keeps stale fields, reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_src   <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (slot_free) begin
      cdb_valid <= grant_vld;
      if (grant_vld) begin
        cdb_src  <= grant;
        cdb_tag  <= mem_tag[grant][rd_ptr[grant]];
        cdb_data <= mem_data[grant][rd_ptr[grant]];
        rr_ptr   <= (grant == SW'(N_SRC - 1)) ? '0 : grant + SW'(1);
      end
    end
  end

  // Activity indicator from registered state only.
  always_comb begin
    busy = !rst && ((|nonempty) || cdb_valid);
  end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for wb_result_arbiter with hand-computed expected results.
module tb_wb_result_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic [19:0] src_tag;
  logic [127:0] src_data;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [1:0]  cdb_src;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        busy;

  logic [4:0]  tg [4];
  logic [31:0] dt [4];

  int n_chk  = 0;
  int n_fail = 0;

  assign src_tag  = {tg[3], tg[2], tg[1], tg[0]};
  assign src_data = {dt[3], dt[2], dt[1], dt[0]};

  always #5 clk = ~clk;

  wb_result_arbiter #(.N_SRC(4), .TAG_W(5), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_src(cdb_src), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cdb(input string nm, input logic v, input logic [1:0] s,
                         input logic [4:0] t, input logic [31:0] d);
    chk({nm, ".valid"}, 64'(cdb_valid), 64'(v));
    if (v) begin
      chk({nm, ".src"},  64'(cdb_src),  64'(s));
      chk({nm, ".tag"},  64'(cdb_tag),  64'(t));
      chk({nm, ".data"}, 64'(cdb_data), 64'(d));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] s;
    rst = 1'b1; flush = 1'b0; src_valid = '0; cdb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin tg[i] = '0; dt[i] = '0; end

    // reset state
    step(); step();
    chk("rst.ready", 64'(src_ready), 64'h0);
    chk("rst.busy",  64'(busy),      64'h0);
    chk("rst.valid", 64'(cdb_valid), 64'h0);
    chk("rst.fields", {cdb_src, cdb_tag, cdb_data}, 64'h0);
    rst = 1'b0;
    #1 chk("post_rst.ready", 64'(src_ready), 64'hf);

    // single ALU result, two-cycle latency
    src_valid = 4'b0001; tg[0] = 5'd3; dt[0] = 32'h11;
    step(); src_valid = '0;
    chk("t1.lat_valid", 64'(cdb_valid), 64'h0);
    chk("t1.lat_busy",  64'(busy),      64'h1);
    step(); chk_cdb("t1.out", 1'b1, 2'd0, 5'd3, 32'h11);
    step();
    chk("t1.drain_valid", 64'(cdb_valid), 64'h0);
    chk("t1.drain_busy",  64'(busy),      64'h0);

    // flush to bring rotation back to source 0
    flush = 1'b1; step(); flush = 1'b0;

    // all four push together from rr_ptr=0
    for (int i = 0; i < 4; i++) begin tg[i] = 5'(i + 1); dt[i] = 32'h100 + 32'(i); end
    src_valid = 4'hf;
    step(); src_valid = '0;
    chk("t2.lat_valid", 64'(cdb_valid), 64'h0);
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      step(); chk_cdb($sformatf("t2.out%0d", k), 1'b1, s, 5'(k + 1), 32'h100 + 32'(k));
    end
    step(); chk("t2.end_valid", 64'(cdb_valid), 64'h0);

    // a lone jump grant moves rotation to branch, then all four push
    src_valid = 4'b0100; tg[2] = 5'd7; dt[2] = 32'h77;
    step(); src_valid = '0;
    step(); chk_cdb("t3.jump", 1'b1, 2'd2, 5'd7, 32'h77);
    step(); chk("t3.jump_drain", 64'(cdb_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin tg[i] = 5'(i + 1); dt[i] = 32'h200 + 32'(i); end
    src_valid = 4'hf;
    step(); src_valid = '0;
    for (int k = 0; k < 4; k++) begin
      s = 2'((3 + k) % 4);
      step(); chk_cdb($sformatf("t3.out%0d", k), 1'b1, s, 5'(s) + 5'd1, 32'h200 + 32'(s));
    end
    step(); chk("t3.end_valid", 64'(cdb_valid), 64'h0);

    // backpressure: ALU pushes every cycle while ROB stalls for 5 cycles
    cdb_ready = 1'b0;
    begin
      logic [4:0] exp_rdy;
      logic [4:0] exp_vld;
      exp_rdy = 5'b00111;
      exp_vld = 5'b11110;
      for (int k = 0; k < 5; k++) begin
        src_valid = 4'b0001; tg[0] = 5'(10 + k); dt[0] = 32'h400 + 32'(k);
        #1 chk($sformatf("t4.ready%0d", k), 64'(src_ready[0]), 64'(exp_rdy[k]));
        step();
        chk_cdb($sformatf("t4.hold%0d", k), exp_vld[k], 2'd0, 5'd10, 32'h400);
      end
    end
    src_valid = '0; cdb_ready = 1'b1;
    step(); chk_cdb("t4.rel1", 1'b1, 2'd0, 5'd11, 32'h401);
    step(); chk_cdb("t4.rel2", 1'b1, 2'd0, 5'd12, 32'h402);
    step(); chk("t4.end_valid", 64'(cdb_valid), 64'h0);

    // flush with two FIFOs occupied and the slot holding a result
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin tg[i] = 5'(20 + i); dt[i] = 32'h500 + 32'(i); end
    src_valid = 4'b0111;
    step(); src_valid = '0;
    step(); chk_cdb("t5.pre", 1'b1, 2'd1, 5'd21, 32'h501);
    chk("t5.pre_busy", 64'(busy), 64'h1);
    flush = 1'b1; src_valid = 4'hf;
    for (int i = 0; i < 4; i++) begin tg[i] = 5'(30 + i); dt[i] = 32'h300 + 32'(i); end
    #1 chk("t5.flush_ready", 64'(src_ready), 64'h0);
    step(); flush = 1'b0; src_valid = '0;
    chk("t5.valid", 64'(cdb_valid), 64'h0);
    chk("t5.busy",  64'(busy),      64'h0);
    #1 chk("t5.ready", 64'(src_ready), 64'hf);
    cdb_ready = 1'b1;
    step(); step();
    chk("t5.late_valid", 64'(cdb_valid), 64'h0);
    chk("t5.late_busy",  64'(busy),      64'h0);

    // full forwarder FIFO: push rejected while popping, accepted next cycle
    cdb_ready = 1'b0; src_valid = 4'b0010;
    tg[1] = 5'd5; dt[1] = 32'h605;
    step(); tg[1] = 5'd6; dt[1] = 32'h606;
    step(); chk_cdb("t6.slot", 1'b1, 2'd1, 5'd5, 32'h605);
    tg[1] = 5'd7; dt[1] = 32'h607;
    step(); chk_cdb("t6.hold", 1'b1, 2'd1, 5'd5, 32'h605);
    cdb_ready = 1'b1; tg[1] = 5'd8; dt[1] = 32'h608;
    #1 chk("t6.full_ready", 64'(src_ready), 64'hd);
    step(); chk_cdb("t6.pop1", 1'b1, 2'd1, 5'd6, 32'h606);
    tg[1] = 5'd9; dt[1] = 32'h609;
    #1 chk("t6.reopen", 64'(src_ready[1]), 64'h1);
    step(); src_valid = '0;
    chk_cdb("t6.pop2", 1'b1, 2'd1, 5'd7, 32'h607);
    step(); chk_cdb("t6.pop3", 1'b1, 2'd1, 5'd9, 32'h609);
    step();
    chk("t6.end_valid", 64'(cdb_valid), 64'h0);
    chk("t6.end_busy",  64'(busy),      64'h0);

    // reset in the middle of activity clears the output fields too
    src_valid = 4'b0001; tg[0] = 5'd1; dt[0] = 32'hab;
    step(); src_valid = '0;
    step(); chk_cdb("t7.pre", 1'b1, 2'd0, 5'd1, 32'hab);
    rst = 1'b1; cdb_ready = 1'b0;
    #1 chk("t7.rst_ready", 64'(src_ready), 64'h0);
    chk("t7.rst_busy", 64'(busy), 64'h0);
    step();
    chk("t7.valid", 64'(cdb_valid), 64'h0);
    chk("t7.fields", {cdb_src, cdb_tag, cdb_data}, 64'h0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
